peridot_board_romreader: RTL and testbench
==========================================

Name: peridot_board_romreader

Overview:
- Reads and parses the 26-byte PERIDOT board serial-ROM image through the byte-read interface: `byteaddr` out, `bytedata` in, plus `ready`.
- Image layout:
  - bytes 0-9: header "J7W", version byte, "J72", generation code, "93".
  - bytes 10-25: sixteen ASCII-hex characters of the 64-bit UID, most significant nibble first.
- Validates the header, converts the ASCII UID back to binary, and presents version, generation code and UID to host-side logic such as the host-bridge config responder and self-test.

Parameters:
- READ_LATENCY, 1: clocks from `byteaddr` change to `bytedata` sampling (1..7).
- EXPECT_VERSION, 8'h02: required value of byte 3.
- TIMEOUT_CYCLES, 255: max clocks waiting for `rom_ready` after `start`; 0 means wait forever.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle request to begin a read pass.
- rom_ready  in  1  ROM source ready.
- byteaddr  out  5  ROM byte address.
- bytedata  in  8  ROM byte data.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at pass end, whether success or error.
- valid  out  1  last pass succeeded; held until the next accepted start.
- error  out  1  last pass failed; held.
- err_code  out  2  0 none, 1 header mismatch, 2 bad hex char, 3 ready timeout.
- err_addr  out  5  byte address at which the failure was detected.
- version  out  8  captured byte 3.
- gencode  out  8  captured byte 7.
- uid  out  64  parsed UID; updated only on success.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state IDLE.
  - busy=0, done=0, valid=0, error=0, err_code=0, err_addr=0.
  - byteaddr=0, version=0, gencode=0, uid=0.
  - Reset mid-pass aborts the pass immediately with no done pulse.
- IDLE:
  - On start=1: busy=1; valid, error and err_code cleared; err_addr cleared; internal UID shift register cleared; byteaddr=0.
  - Then go to WAITRDY.
- start while busy=1 is ignored.
- WAITRDY:
  - If rom_ready=1, go to FETCH.
  - Otherwise the timeout counter increments.
  - When the counter reaches TIMEOUT_CYCLES (nonzero parameter), finish with error code 3, err_addr=0.
- FETCH:
  - byteaddr holds the current address; wait READ_LATENCY clocks, then sample bytedata in CHECK.
  - Each byte therefore costs READ_LATENCY+1 clocks.
- CHECK, by address:
  - 0,1,2: must be 8'h4a, 8'h37, 8'h57.
  - 3: must equal EXPECT_VERSION; captured into version either way.
  - 4,5,6: must be 8'h4a, 8'h37, 8'h32.
  - 7: any value; captured into gencode.
  - 8,9: must be 8'h39, 8'h33.
  - 10..25: must be 8'h30-39, 8'h41-46 or 8'h61-66.
    - Mapped nibble is shifted in: shreg <= {shreg[59:0], nib}.
  - A mismatch on a header byte finishes with code 1; a bad hex character finishes with code 2.
    - err_addr = the failing address.
    - No further bytes are read.
  - Address < 25 and no error: byteaddr increments, return to FETCH.
  - Address 25 and no error: uid <= final shift value, valid=1.
- rom_ready is sampled only in WAITRDY. A ready drop during the fetch loop is not checked.
- DONE:
  - done=1 for exactly one clock, busy=0, then IDLE.
  - busy falls in the same cycle done rises.
  - valid and error outputs change in the cycle done=1.
  - valid and error are never both 1.
- Latency with READ_LATENCY=1 and rom_ready already 1:
  - start at cycle 0, WAITRDY cycle 1, first FETCH cycle 2.
  - 26 bytes take 52 clocks; done asserts at cycle 54.
- byteaddr never exceeds 25.
- uid retains its previous successful value through failed passes.

Test Plan:
1. rom_ready=1, image "J7W",02,"J72",4E,"93","0123456789ABCDEF", READ_LATENCY=1, start pulse → done at cycle 54; valid=1, uid=64'h0123456789ABCDEF, version=02, gencode=4E, err_code=0.
2. Same image with byte 10 = 8'h61 ('a') → valid, uid[63:60]=4'hA. Then byte 14 = 8'h47 ('G') → error=1, err_code=2, err_addr=14, uid unchanged from the previous pass.
3. Byte 3 = 8'h03 → error, err_code=1, err_addr=3, version=03. Byte 8 = 8'h38 → err_code=1, err_addr=8.
4. rom_ready held 0, TIMEOUT_CYCLES=255 → err_code=3, err_addr=0, done pulse. With TIMEOUT_CYCLES=0, busy stays 1 until rom_ready rises, then the pass succeeds.
5. READ_LATENCY=3, bytedata delayed exactly 3 clocks by the model → success; done at cycle 2+26*4=106. Assert the reset_n pulse mid-pass → all outputs return to reset values, no done pulse; the next start succeeds.
6. Second start issued while busy=1 → ignored, single done pulse. Back-to-back start on the cycle after done → new pass accepted.

Source files
------------

// File: rtl/peridot_board_romreader.sv
// PERIDOT board serial-ROM reader: fetches the 26-byte image, validates the
// header, converts the ASCII-hex UID to binary and reports version/gencode/uid.
module peridot_board_romreader #(
  parameter int unsigned READ_LATENCY   = 1,
  parameter logic [7:0]  EXPECT_VERSION = 8'h02,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        rom_ready,
  output logic [4:0]  byteaddr,
  input  logic [7:0]  bytedata,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [4:0]  err_addr,
  output logic [7:0]  version,
  output logic [7:0]  gencode,
  output logic [63:0] uid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITRDY,
    S_FETCH,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      state, state_next;
  logic [2:0]  lat_cnt;
  logic [31:0] tmo_cnt;
  logic [63:0] shreg;

  logic        hex_ok;
  logic [3:0]  nib;
  logic [7:0]  exp_byte;
  logic        bad;
  logic        finish_ok;
  logic        finish_err;
  logic [1:0]  code_next;

  // Byte classification for the current address
  always_comb begin
    hex_ok = 1'b1;
    nib    = '0;
    if (bytedata >= 8'h30 && bytedata <= 8'h39)
      nib = bytedata[3:0];
    else if ((bytedata >= 8'h41 && bytedata <= 8'h46) ||
             (bytedata >= 8'h61 && bytedata <= 8'h66))
      nib = bytedata[3:0] + 4'd9;
    else
      hex_ok = 1'b0;

    case (byteaddr)
      5'd0:    exp_byte = 8'h4a;
      5'd1:    exp_byte = 8'h37;
      5'd2:    exp_byte = 8'h57;
      5'd3:    exp_byte = EXPECT_VERSION;
      5'd4:    exp_byte = 8'h4a;
      5'd5:    exp_byte = 8'h37;
      5'd6:    exp_byte = 8'h32;
      5'd8:    exp_byte = 8'h39;
      5'd9:    exp_byte = 8'h33;
      default: exp_byte = 8'h00;
    endcase

    if (byteaddr < 5'd10)
      bad = (byteaddr != 5'd7) && (bytedata != exp_byte);
    else
      bad = !hex_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    finish_ok  = 1'b0;
    finish_err = 1'b0;
    code_next  = '0;
    case (state)
      S_IDLE:
        if (start) state_next = S_WAITRDY;
      S_WAITRDY:
        if (rom_ready) begin
          state_next = S_FETCH;
        end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TIMEOUT_CYCLES - 1) begin
          state_next = S_DONE;
          finish_err = 1'b1;
          code_next  = 2'd3;
        end
      S_FETCH:
        if (lat_cnt == 3'(READ_LATENCY - 1)) state_next = S_CHECK;
      S_CHECK:
        if (bad) begin
          state_next = S_DONE;
          finish_err = 1'b1;
          code_next  = (byteaddr < 5'd10) ? 2'd1 : 2'd2;
        end else if (byteaddr == 5'd25) begin
          state_next = S_DONE;
          finish_ok  = 1'b1;
        end else begin
          state_next = S_FETCH;
        end
      S_DONE:
        state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  assign busy = (state == S_WAITRDY) || (state == S_FETCH) || (state == S_CHECK);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      byteaddr <= '0;
      valid    <= 1'b0;
      error    <= 1'b0;
      err_code <= '0;
      err_addr <= '0;
      version  <= '0;
      gencode  <= '0;
      uid      <= '0;
      shreg    <= '0;
      lat_cnt  <= '0;
      tmo_cnt  <= '0;
    end else begin
      lat_cnt <= (state == S_FETCH) ? lat_cnt + 3'd1 : '0;
      tmo_cnt <= (state == S_WAITRDY) ? tmo_cnt + 32'd1 : '0;

      if (state == S_IDLE && start) begin
        byteaddr <= '0;
        valid    <= 1'b0;
        error    <= 1'b0;
        err_code <= '0;
        err_addr <= '0;
        shreg    <= '0;
      end

      if (state == S_CHECK) begin
        if (byteaddr == 5'd3) version <= bytedata;
        if (byteaddr == 5'd7) gencode <= bytedata;
        if (byteaddr >= 5'd10 && hex_ok) shreg <= {shreg[59:0], nib};
        if (!bad && byteaddr != 5'd25) byteaddr <= byteaddr + 5'd1;
      end

      if (finish_ok) begin
        uid   <= {shreg[59:0], nib};
        valid <= 1'b1;
      end

      if (finish_err) begin
        error    <= 1'b1;
        err_code <= code_next;
        err_addr <= (code_next == 2'd3) ? 5'd0 : byteaddr;
      end
    end
  end

endmodule

// File: tb/tb_peridot_board_romreader.sv
// Directed bench for peridot_board_romreader: three instances cover the default
// configuration, an infinite ready wait and a 3-clock read latency.
module tb_peridot_board_romreader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        rdy;
  int          sel;
  logic [7:0]  rom [0:31];

  logic [2:0]  start_v;
  logic [2:0]  done_v, busy_v, valid_v, error_v;
  logic [1:0]  ec_v  [3];
  logic [4:0]  ea_v  [3];
  logic [4:0]  ba_v  [3];
  logic [7:0]  ver_v [3];
  logic [7:0]  gen_v [3];
  logic [7:0]  bd_v  [3];
  logic [63:0] uid_v [3];
  logic [7:0]  p1, p2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign start_v[0] = start && (sel == 0);
  assign start_v[1] = start && (sel == 1);
  assign start_v[2] = start && (sel == 2);

  peridot_board_romreader #(.READ_LATENCY(1), .EXPECT_VERSION(8'h02), .TIMEOUT_CYCLES(255)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .rom_ready(rdy),
    .byteaddr(ba_v[0]), .bytedata(bd_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .valid(valid_v[0]), .error(error_v[0]), .err_code(ec_v[0]), .err_addr(ea_v[0]),
    .version(ver_v[0]), .gencode(gen_v[0]), .uid(uid_v[0]));

  peridot_board_romreader #(.READ_LATENCY(1), .EXPECT_VERSION(8'h02), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .rom_ready(rdy),
    .byteaddr(ba_v[1]), .bytedata(bd_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .valid(valid_v[1]), .error(error_v[1]), .err_code(ec_v[1]), .err_addr(ea_v[1]),
    .version(ver_v[1]), .gencode(gen_v[1]), .uid(uid_v[1]));

  peridot_board_romreader #(.READ_LATENCY(3), .EXPECT_VERSION(8'h02), .TIMEOUT_CYCLES(255)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .rom_ready(rdy),
    .byteaddr(ba_v[2]), .bytedata(bd_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .valid(valid_v[2]), .error(error_v[2]), .err_code(ec_v[2]), .err_addr(ea_v[2]),
    .version(ver_v[2]), .gencode(gen_v[2]), .uid(uid_v[2]));

  // ROM models: one-clock read for a/b, three-clock read for c
  always @(posedge clk) begin
    bd_v[0] <= rom[ba_v[0]];
    bd_v[1] <= rom[ba_v[1]];
    p1      <= rom[ba_v[2]];
    p2      <= p1;
    bd_v[2] <= p2;
  end

  logic        m_done, m_busy, m_valid, m_error;
  logic [1:0]  m_ec;
  logic [4:0]  m_ea, m_ba;
  logic [7:0]  m_ver, m_gen;
  logic [63:0] m_uid;
  assign m_done  = done_v[sel];
  assign m_busy  = busy_v[sel];
  assign m_valid = valid_v[sel];
  assign m_error = error_v[sel];
  assign m_ec    = ec_v[sel];
  assign m_ea    = ea_v[sel];
  assign m_ba    = ba_v[sel];
  assign m_ver   = ver_v[sel];
  assign m_gen   = gen_v[sel];
  assign m_uid   = uid_v[sel];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_image();
    string hdr = "J7W";
    string uidstr = "0123456789ABCDEF";
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    for (int i = 0; i < 3; i++) rom[i] = hdr[i];
    rom[3] = 8'h02;
    rom[4] = 8'h4a; rom[5] = 8'h37; rom[6] = 8'h32;
    rom[7] = 8'h4e;
    rom[8] = 8'h39; rom[9] = 8'h33;
    for (int i = 0; i < 16; i++) rom[10 + i] = uidstr[i];
  endtask

  // Leaves the bench just after the edge that samples start (cycle 1)
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the cycle (start cycle = 0) in which done is seen, 0 if never
  task automatic wait_done(input int max, output int cyc);
    int n = 1;
    cyc = 0;
    while (n <= max) begin
      @(negedge clk);
      if (m_done) begin
        cyc = n;
        break;
      end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic run(input int max, output int cyc);
    pulse_start();
    wait_done(max, cyc);
  endtask

  int cyc;
  int cnt;
  bit bad;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    rdy     = 1'b1;
    sel     = 0;
    load_image();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", m_busy, 0);
    chk("rst_done", m_done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_error", m_error, 0);
    chk("rst_err_code", m_ec, 0);
    chk("rst_err_addr", m_ea, 0);
    chk("rst_byteaddr", m_ba, 0);
    chk("rst_version", m_ver, 0);
    chk("rst_gencode", m_gen, 0);
    chk("rst_uid", m_uid, 0);
    reset_n = 1'b1;

    // 1: nominal image
    run(200, cyc);
    chk("t1_done_cycle", cyc, 54);
    chk("t1_busy_at_done", m_busy, 0);
    chk("t1_valid", m_valid, 1);
    chk("t1_error", m_error, 0);
    chk("t1_uid", m_uid, 64'h0123456789ABCDEF);
    chk("t1_version", m_ver, 8'h02);
    chk("t1_gencode", m_gen, 8'h4e);
    chk("t1_err_code", m_ec, 0);
    @(negedge clk);
    chk("t1_done_one_cycle", m_done, 0);
    chk("t1_valid_held", m_valid, 1);

    // 2: lower-case hex, then a bad hex char
    rom[10] = 8'h61;
    run(200, cyc);
    chk("t2a_valid", m_valid, 1);
    chk("t2a_uid", m_uid, 64'hA123456789ABCDEF);
    rom[14] = 8'h47;
    run(200, cyc);
    chk("t2b_got_done", cyc != 0, 1);
    chk("t2b_error", m_error, 1);
    chk("t2b_valid", m_valid, 0);
    chk("t2b_err_code", m_ec, 2);
    chk("t2b_err_addr", m_ea, 14);
    chk("t2b_uid_kept", m_uid, 64'hA123456789ABCDEF);
    load_image();

    // 3: header mismatches
    rom[3] = 8'h03;
    run(200, cyc);
    chk("t3a_error", m_error, 1);
    chk("t3a_err_code", m_ec, 1);
    chk("t3a_err_addr", m_ea, 3);
    chk("t3a_version", m_ver, 8'h03);
    load_image();
    rom[8] = 8'h38;
    run(200, cyc);
    chk("t3b_err_code", m_ec, 1);
    chk("t3b_err_addr", m_ea, 8);
    chk("t3b_version", m_ver, 8'h02);
    load_image();

    // 4: ready timeout, then infinite wait on the TIMEOUT_CYCLES=0 instance
    rdy = 1'b0;
    run(1000, cyc);
    chk("t4a_got_done", cyc != 0, 1);
    chk("t4a_error", m_error, 1);
    chk("t4a_valid", m_valid, 0);
    chk("t4a_err_code", m_ec, 3);
    chk("t4a_err_addr", m_ea, 0);
    sel = 1;
    pulse_start();
    bad = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (!m_busy || m_done) bad = 1'b1;
    end
    chk("t4b_busy_held", bad, 0);
    rdy = 1'b1;
    wait_done(200, cyc);
    chk("t4b_got_done", cyc != 0, 1);
    chk("t4b_valid", m_valid, 1);
    chk("t4b_uid", m_uid, 64'h0123456789ABCDEF);

    // 5: READ_LATENCY=3, then a reset mid-pass
    sel = 2;
    run(400, cyc);
    chk("t5_done_cycle", cyc, 106);
    chk("t5_valid", m_valid, 1);
    chk("t5_uid", m_uid, 64'h0123456789ABCDEF);
    pulse_start();
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5r_busy", m_busy, 0);
    chk("t5r_valid", m_valid, 0);
    chk("t5r_uid", m_uid, 0);
    chk("t5r_version", m_ver, 0);
    chk("t5r_byteaddr", m_ba, 0);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (m_done || m_busy) bad = 1'b1;
    end
    chk("t5r_no_done", bad, 0);
    run(400, cyc);
    chk("t5r_next_cycle", cyc, 106);
    chk("t5r_next_valid", m_valid, 1);

    // 6: start while busy ignored; back-to-back start after done
    sel = 0;
    pulse_start();
    repeat (10) @(posedge clk);
    pulse_start();
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (m_done) cnt++;
    end
    chk("t6_single_done", cnt, 1);
    chk("t6_valid", m_valid, 1);
    run(200, cyc);
    chk("t6_first_cycle", cyc, 54);
    run(200, cyc);
    chk("t6_b2b_cycle", cyc, 54);
    chk("t6_b2b_valid", m_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
